serial_adder_ctrl: RTL and testbench

Multi-cycle sequencer that performs wide unsigned addition by time-sharing one CHUNK_BITS-wide ripple-adder stage, the same function as adder_nbit, across NUM_CHUNKS clock cycles. It captures the operands on a start request and walks the chunks LSB-first, carrying between cycles. It then presents the registered sum and overflow with a one-cycle done pulse. It sits between a requesting controller and the adder datapath, so wide operands do not need a wide combinational adder.

---
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Wide unsigned adder that time-shares one CHUNK_BITS-wide adder stage over
// NUM_CHUNKS cycles, LSB chunk first, and presents a registered sum/overflow.
module serial_adder_ctrl #(
    parameter int CHUNK_BITS = 4,
    parameter int NUM_CHUNKS = 4,
    localparam int W = CHUNK_BITS * NUM_CHUNKS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         overflow
);

    localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic                carry_q, carry_d;
    logic [CW-1:0]       count_q, count_d;
    logic [W-1:0]        res_q, res_d;
    logic [W-1:0]        sum_q, sum_d;
    logic                ovf_q, ovf_d;
    logic [CHUNK_BITS:0] chunk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            count_q <= count_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        count_d = count_q;
        res_d   = res_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        chunk   = {1'b0, a_q[CHUNK_BITS-1:0]} + {1'b0, b_q[CHUNK_BITS-1:0]}
                + (CHUNK_BITS+1)'(carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    count_d = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d     = a_q >> CHUNK_BITS;
                b_d     = b_q >> CHUNK_BITS;
                carry_d = chunk[CHUNK_BITS];
                // Each new chunk enters at the top, so after NUM_CHUNKS steps chunk 0 sits at the LSB.
                res_d   = (res_q >> CHUNK_BITS)
                        | (W'(chunk[CHUNK_BITS-1:0]) << (W - CHUNK_BITS));
                if (count_q == LAST) begin
                    sum_d   = res_d;
                    ovf_d   = chunk[CHUNK_BITS];
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == ADD);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: a cycle-timing/arithmetic model per instance (16-bit
// default and 6-bit CHUNK_BITS=2/NUM_CHUNKS=3) plus directed literal checks.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit sweep = 1'b0;

    logic        rst_v   [2];
    logic        start_v [2];
    logic [15:0] a_v     [2];
    logic [15:0] b_v     [2];
    logic        cin_v   [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        ovf_v   [2];
    logic [15:0] sum_v   [2];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int CB = (gi == 0) ? 4 : 2;
        localparam int NC = (gi == 0) ? 4 : 3;
        localparam int W  = CB * NC;

        logic         busy_w, done_w, ovf_w;
        logic [W-1:0] sum_w;

        serial_adder_ctrl #(.CHUNK_BITS(CB), .NUM_CHUNKS(NC)) dut (
            .clk      (clk),
            .rst      (rst_v[gi]),
            .start    (start_v[gi]),
            .a        (a_v[gi][W-1:0]),
            .b        (b_v[gi][W-1:0]),
            .carry_in (cin_v[gi]),
            .busy     (busy_w),
            .done     (done_w),
            .sum      (sum_w),
            .overflow (ovf_w)
        );

        assign busy_v[gi] = busy_w;
        assign done_v[gi] = done_w;
        assign ovf_v[gi]  = ovf_w;
        assign sum_v[gi]  = 16'(sum_w);

        // Model: an op accepted at cycle t is busy for t..t+NC-1, done at t+NC,
        // and the next one may be accepted no earlier than t+NC+2.
        int         cyc       = 0;
        int         last_acc  = -1000;
        int         prev_done = -1;
        logic [W:0] pend      = '0;
        logic [W:0] exp_res   = '0;

        always @(negedge clk) begin
            if (rst_v[gi]) begin
                last_acc = -1000;
                exp_res  = '0;
            end else if (cyc == last_acc + NC) begin
                exp_res = pend;
            end
            check($sformatf("i%0d busy c%0d", gi, cyc), busy_w,
                  (cyc >= last_acc && cyc < last_acc + NC) ? 1 : 0);
            check($sformatf("i%0d done c%0d", gi, cyc), done_w,
                  (cyc == last_acc + NC) ? 1 : 0);
            check($sformatf("i%0d sum c%0d", gi, cyc), sum_w, exp_res[W-1:0]);
            check($sformatf("i%0d ovf c%0d", gi, cyc), ovf_w, exp_res[W]);
            if (done_w) begin
                if (sweep && prev_done >= 0)
                    check($sformatf("i%0d spacing c%0d", gi, cyc), cyc - prev_done, NC + 2);
                prev_done = cyc;
            end
            if (!sweep) prev_done = -1;
            cyc++;
            if (!rst_v[gi] && start_v[gi] && cyc >= last_acc + NC + 2) begin
                last_acc = cyc;
                pend = {1'b0, a_v[gi][W-1:0]} + {1'b0, b_v[gi][W-1:0]} + (W+1)'(cin_v[gi]);
            end
        end
    end

    // Pulse start for one accepted edge, then scramble the operand inputs.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] es, input logic eo, input string name);
        int nb;
        bit got;
        @(posedge clk); #1;
        start_v[0] = 1'b1; a_v[0] = a; b_v[0] = b; cin_v[0] = c;
        @(posedge clk); #1;
        start_v[0] = 1'b0; a_v[0] = 16'($urandom); b_v[0] = 16'($urandom); cin_v[0] = 1'($urandom);
        nb = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done_v[0]) got = 1'b1;
            else if (busy_v[0]) nb++;
        end
        check({name, " done seen"}, got, 1);
        check({name, " busy cycles"}, nb, 4);
        check({name, " sum"}, sum_v[0], es);
        check({name, " ovf"}, ovf_v[0], eo);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_v[0]) n++;
        end
    endtask

    initial begin
        int  n, n0, n1;
        bit  got;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        @(negedge clk);
        check("reset busy", busy_v[0], 0);
        check("reset done", done_v[0], 0);
        check("reset sum", sum_v[0], 0);

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple_b1");
        run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple_cin");
        run_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, "ripple_mid");

        // Second start during busy with different operands must be ignored.
        @(posedge clk); #1;
        start_v[0] = 1'b1; a_v[0] = 16'h00FF; b_v[0] = 16'h0001; cin_v[0] = 1'b0;
        @(posedge clk); #1; start_v[0] = 1'b0;
        @(posedge clk); #1; start_v[0] = 1'b1; a_v[0] = 16'hFFFF;
        @(posedge clk); #1; start_v[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done_v[0]) got = 1'b1;
        end
        check("iso done seen", got, 1);
        check("iso sum", sum_v[0], 16'h0100);
        check("iso ovf", ovf_v[0], 0);
        count_dones(12, n);
        check("iso no second op", n, 0);

        // Start held high: next done follows NUM_CHUNKS+2 cycles later.
        @(posedge clk); #1;
        start_v[0] = 1'b1; a_v[0] = 16'h0001; b_v[0] = 16'h0002;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done_v[0]) got = 1'b1;
        end
        check("held first done", got, 1);
        n = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (done_v[0]) got = 1'b1;
        end
        check("held done gap", n, 6);
        @(posedge clk); #1; start_v[0] = 1'b0;
        count_dones(8, n);
        check("held released quiet", n, 0);

        // Reset mid-operation.
        @(posedge clk); #1;
        start_v[0] = 1'b1; a_v[0] = 16'hAAAA; b_v[0] = 16'h5555;
        @(posedge clk); #1; start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_v[0] = 1'b1;
        #1;
        check("midrst busy", busy_v[0], 0);
        check("midrst done", done_v[0], 0);
        check("midrst sum", sum_v[0], 0);
        check("midrst ovf", ovf_v[0], 0);
        @(posedge clk); #1; rst_v[0] = 1'b0;
        count_dones(10, n);
        check("midrst no done", n, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "after_rst");

        // Reset and start in the same cycle: reset wins.
        @(posedge clk); #1;
        rst_v[0] = 1'b1; start_v[0] = 1'b1; a_v[0] = 16'h0005;
        @(posedge clk); #1;
        rst_v[0] = 1'b0; start_v[0] = 1'b0;
        @(negedge clk);
        check("rst+start busy", busy_v[0], 0);

        // Random back-to-back sweep on both instances with start held high.
        sweep = 1'b1;
        n0 = 0; n1 = 0;
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        repeat (520 * 6) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                a_v[i] = 16'($urandom); b_v[i] = 16'($urandom); cin_v[i] = 1'($urandom);
            end
            @(negedge clk);
            if (done_v[0]) n0++;
            if (done_v[1]) n1++;
        end
        @(posedge clk); #1;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) n0++;
            if (done_v[1]) n1++;
        end
        sweep = 1'b0;
        check("sweep ops inst0 >= 512", (n0 >= 512) ? 1 : 0, 1);
        check("sweep ops inst1 >= 512", (n1 >= 512) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
